// File: rtl/cpri_tx_pkt_sched_pkg.sv
// Shared types and default geometry for the CPRI TX packet scheduler.
// Default sizing matches one 48-beat packet per 64-beat slot, two slots deep.
package cpri_tx_pkt_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_DW      = 64;
    localparam int DEF_PKT_LEN = 48;
    localparam int DEF_BEAT_W  = 6;
    localparam int DEF_SLOT_W  = 1;
    localparam int CPRI_ADDR_W = DEF_SLOT_W + DEF_BEAT_W;

endpackage

// File: rtl/cpri_tx_pkt_sched_rr_pick.sv
// Combinational round-robin selector: first valid index at or above ptr, cyclic.
// ptr must be below N.
module cpri_tx_pkt_sched_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        sum    = '0;
        cand   = '0;
        any    = |valid;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IW + 1)'(i);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            cand = sum[IW-1:0];
            if (valid[cand]) begin
                onehot       = '0;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/cpri_tx_pkt_sched.sv
// Packet-granular round-robin scheduler for the CPRI TX slot-buffer write port,
// with slot credits returned by the read side.
//
//   state | meaning
//   IDLE  | no packet owns the port; grant when a slot credit is free
//   BUSY  | granted requester streams beats until its packet ends
module cpri_tx_pkt_sched
    import cpri_tx_pkt_sched_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int DW      = DEF_DW,
    parameter int PKT_LEN = DEF_PKT_LEN,
    parameter int BEAT_W  = DEF_BEAT_W,
    parameter int SLOT_W  = DEF_SLOT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ*DW-1:0]       i_req_data,
    input  logic [NREQ-1:0]          i_req_last,
    output logic [NREQ-1:0]          o_req_ready,
    input  logic                     i_slot_free,
    input  logic                     i_flush,
    output logic                     o_cpri_wen,
    output logic [SLOT_W+BEAT_W-1:0] o_cpri_waddr,
    output logic [DW-1:0]            o_cpri_wdata,
    output logic                     o_cpri_wlast,
    output logic [NREQ-1:0]          o_gnt,
    output logic                     o_busy,
    output logic [SLOT_W:0]          o_credit,
    output logic                     o_len_err
);

    localparam int                NSLOT      = 2 ** SLOT_W;
    localparam int                IW         = $clog2(NREQ);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(PKT_LEN - 1);
    localparam logic [SLOT_W:0]   CREDIT_MAX = (SLOT_W + 1)'(NSLOT);
    localparam logic [IW-1:0]     LAST_REQ   = IW'(NREQ - 1);

    sched_state_t        state, state_nx;
    logic [NREQ-1:0]     gnt;
    logic [IW-1:0]       gnt_idx;
    logic [IW-1:0]       rr_ptr;
    logic [SLOT_W-1:0]   slot;
    logic [BEAT_W-1:0]   beat;
    logic [SLOT_W:0]     credit;

    logic [NREQ-1:0]     pick_oh;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic [DW-1:0]       sel_data;
    logic                sel_last;
    logic                grant;
    logic                accept;
    logic                pkt_end;
    logic                at_last_beat;

    cpri_tx_pkt_sched_rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .valid  (i_req_valid),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int n = 0; n < NREQ; n++) begin
            if (gnt[n]) begin
                sel_data = i_req_data[n*DW +: DW];
                sel_last = i_req_last[n];
            end
        end
    end

    assign at_last_beat = (beat == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        accept   = 1'b0;
        pkt_end  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any && credit != '0) begin
                    grant    = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                accept  = |(i_req_valid & gnt);
                pkt_end = accept && (at_last_beat || sel_last);
                if (pkt_end) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (i_flush) begin
            state_nx = IDLE;
            grant    = 1'b0;
            accept   = 1'b0;
            pkt_end  = 1'b0;
        end
    end

    // Flush drops the packet and credits but leaves rr_ptr so fairness survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= '0;
            gnt_idx <= '0;
            rr_ptr  <= '0;
            slot    <= '0;
            beat    <= '0;
            credit  <= CREDIT_MAX;
        end else if (i_flush) begin
            gnt    <= '0;
            slot   <= '0;
            beat   <= '0;
            credit <= CREDIT_MAX;
        end else begin
            if (grant) begin
                gnt     <= pick_oh;
                gnt_idx <= pick_idx;
            end
            if (accept) begin
                beat <= pkt_end ? '0 : beat + 1'b1;
            end
            if (pkt_end) begin
                gnt    <= '0;
                slot   <= slot + 1'b1;
                rr_ptr <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
            end
            if (grant && !i_slot_free) begin
                credit <= credit - 1'b1;
            end else if (!grant && i_slot_free && credit != CREDIT_MAX) begin
                credit <= credit + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cpri_wen   <= 1'b0;
            o_cpri_waddr <= '0;
            o_cpri_wdata <= '0;
            o_cpri_wlast <= 1'b0;
            o_len_err    <= 1'b0;
        end else begin
            o_cpri_wen   <= accept;
            o_cpri_wlast <= pkt_end;
            // Early last and forced last are both length violations.
            o_len_err    <= pkt_end && (at_last_beat != sel_last);
            if (accept) begin
                o_cpri_waddr <= {slot, beat};
                o_cpri_wdata <= sel_data;
            end
        end
    end

    assign o_gnt       = gnt;
    assign o_req_ready = gnt;
    assign o_busy      = (state == BUSY);
    assign o_credit    = credit;

endmodule
